fp52_res_pack: RTL and testbench

//  Result-side counterpart of mul_fp52. Takes its 18-bit fixed-point res and
//  re-encodes it into the fp52 operand fields (sign, 2b exp, 5b man, denorm).

---
 rtl/fp52_pkg.sv | 22 ++
 rtl/lzd17.sv | 21 ++
 rtl/fp52_res_pack.sv | 158 +++++++++++++++
 tb/tb_fp52_res_pack.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp52_pkg.sv
// Shared fp52 format constants and the packed operand type used by the MAC
// datapath and the result re-packer.
package fp52_pkg;

    localparam int unsigned RES_W    = 18;
    localparam int unsigned FRAC_W   = 12;
    localparam int unsigned MAN_W    = 5;
    localparam int unsigned EXP_W    = 2;
    localparam int unsigned EXP_BIAS = 1;
    localparam int unsigned EXP_MAX  = 3;
    localparam int unsigned MAN_MAX  = 31;
    localparam int unsigned MAG_W    = RES_W - 1;
    localparam int unsigned POS_W    = 5;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             denorm;
    } fp52_t;

endpackage

// File: rtl/lzd17.sv
// Leading-one detector over the 17-bit magnitude: bit index of the highest set
// bit plus an all-zero flag.
module lzd17
    import fp52_pkg::*;
(
    input  logic [MAG_W-1:0] bits,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        pos = '0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (bits[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|bits;

endmodule

// File: rtl/fp52_res_pack.sv
// Re-encodes the 18-bit signed fixed-point MAC result into fp52 fields through
// a 3-stage valid/ready pipeline: leading-one detect, align, RNE round/pack.
module fp52_res_pack
    import fp52_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_denorm,
    output logic             out_ovf,
    output logic             out_unf
);

    localparam int unsigned SUM_W  = MAN_W + 1;
    localparam int unsigned EXPR_W = EXP_W + 1;

    logic ld1, ld2, ld3;

    logic             s1_valid, s1_sign, s1_zero;
    logic [MAG_W-1:0] s1_mag;
    logic [POS_W-1:0] s1_pos;
    logic [POS_W-1:0] lzd_pos;
    logic             lzd_zero;

    logic             s2_valid, s2_sign, s2_zero, s2_sat, s2_guard, s2_sticky;
    logic [EXP_W-1:0] s2_exp;
    logic [MAN_W-1:0] s2_man;

    logic [POS_W-1:0] al_sh;
    logic [EXP_W-1:0] al_exp;
    logic [MAN_W-1:0] al_man;
    logic             al_guard, al_sticky, al_sat;

    logic              rnd_inc;
    logic [SUM_W-1:0]  rnd_sum;
    logic [EXPR_W-1:0] rnd_exp;
    fp52_t             pk_res, res_q;
    logic              pk_ovf, pk_unf;

    // Each stage advances when empty or when the stage downstream advances.
    assign ld3      = !out_valid || out_ready;
    assign ld2      = !s2_valid || ld3;
    assign ld1      = !s1_valid || ld2;
    assign in_ready = ld1;

    lzd17 u_lzd (
        .bits (in_res[MAG_W-1:0]),
        .pos  (lzd_pos),
        .zero (lzd_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mag   <= '0;
            s1_pos   <= '0;
        end else if (ld1) begin
            s1_valid <= in_valid;
            s1_sign  <= in_res[RES_W-1];
            s1_zero  <= lzd_zero;
            s1_mag   <= in_res[MAG_W-1:0];
            s1_pos   <= lzd_pos;
        end
    end

    // Align: denormals share the 2^0 window, normals shift by the leading-one position.
    always_comb begin
        al_sat = s1_pos > POS_W'(FRAC_W + EXP_MAX - EXP_BIAS);
        if (s1_pos < POS_W'(FRAC_W)) begin
            al_sh  = POS_W'(FRAC_W - MAN_W);
            al_exp = '0;
        end else begin
            al_sh  = s1_pos - POS_W'(MAN_W);
            al_exp = EXP_W'(s1_pos - POS_W'(FRAC_W - EXP_BIAS));
        end
        al_man    = MAN_W'(s1_mag >> al_sh);
        al_guard  = 1'(s1_mag >> (al_sh - POS_W'(1)));
        al_sticky = |(s1_mag & ((MAG_W'(1) << (al_sh - POS_W'(1))) - MAG_W'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_sat    <= 1'b0;
            s2_exp    <= '0;
            s2_man    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
        end else if (ld2) begin
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero;
            s2_sat    <= al_sat;
            s2_exp    <= al_exp;
            s2_man    <= al_man;
            s2_guard  <= al_guard;
            s2_sticky <= al_sticky;
        end
    end

    // Mantissa carry lands in the exponent; a carry from 31 leaves man at 0.
    always_comb begin
        rnd_inc = s2_guard & (s2_sticky | s2_man[0]);
        rnd_sum = {1'b0, s2_man} + SUM_W'(rnd_inc);
        rnd_exp = {1'b0, s2_exp} + EXPR_W'(rnd_sum[MAN_W]);

        pk_res.sign   = s2_sign;
        pk_res.exp    = rnd_exp[EXP_W-1:0];
        pk_res.man    = rnd_sum[MAN_W-1:0];
        pk_res.denorm = (rnd_exp == '0);
        pk_ovf        = 1'b0;
        pk_unf        = (rnd_exp == '0) && (rnd_sum[MAN_W-1:0] == '0);

        if (s2_sat || rnd_exp > EXPR_W'(EXP_MAX)) begin
            pk_res.exp    = EXP_W'(EXP_MAX);
            pk_res.man    = MAN_W'(MAN_MAX);
            pk_res.denorm = 1'b0;
            pk_ovf        = 1'b1;
            pk_unf        = 1'b0;
        end else if (s2_zero) begin
            pk_res.exp    = '0;
            pk_res.man    = '0;
            pk_res.denorm = 1'b1;
            pk_unf        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            res_q     <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (ld3) begin
            out_valid <= s2_valid;
            res_q     <= pk_res;
            out_ovf   <= pk_ovf;
            out_unf   <= pk_unf;
        end
    end

    assign out_sign   = res_q.sign;
    assign out_exp    = res_q.exp;
    assign out_man    = res_q.man;
    assign out_denorm = res_q.denorm;

endmodule

// File: tb/tb_fp52_res_pack.sv
// Self-checking bench for fp52_res_pack: directed corner values, backpressure,
// mid-flight reset and randomized traffic against a nearest-code reference model.
module tb_fp52_res_pack;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_ready, out_valid;
    logic        out_sign, out_denorm, out_ovf, out_unf;
    logic [17:0] in_res;
    logic [1:0]  out_exp;
    logic [4:0]  out_man;

    fp52_res_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_man    (out_man),
        .out_denorm (out_denorm),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] f;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0, cyc = 0, n_out = 0;
    bit          lat_chk = 0, have_dir = 0, accepted = 0;
    logic [10:0] next_exp;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // {sign, exp, man, denorm, ovf, unf}
    function automatic logic [10:0] pk(bit s, int e, int m, bit d, bit o, bit u);
        return {s, 2'(e), 5'(m), d, o, u};
    endfunction

    function automatic logic [10:0] obs();
        return {out_sign, out_exp, out_man, out_denorm, out_ovf, out_unf};
    endfunction

    // Value-level reference: pick the nearest of the 128 codes (units of 2^-12),
    // ties to the even code; saturate beyond the max code's rounding boundary.
    function automatic logic [10:0] model(logic [17:0] r);
        int mag, best_k, best_d, e, m, v, d;
        mag    = int'(r[16:0]);
        best_k = 0;
        best_d = -1;
        if (mag >= 32512) return pk(r[17], 3, 31, 0, 1, 0);
        for (int k = 0; k < 128; k++) begin
            e = k / 32;
            m = k % 32;
            v = (e == 0) ? m * 128 : (32 + m) << (e + 6);
            d = (mag > v) ? mag - v : v - mag;
            if (best_d < 0 || d < best_d || (d == best_d && (k % 2) == 0)) begin
                best_d = d;
                best_k = k;
            end
        end
        e = best_k / 32;
        m = best_k % 32;
        return pk(r[17], e, m, e == 0, 0, (mag != 0) && (best_k == 0));
    endfunction

    task automatic check(string tag, int o, int x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, x);
        end
    endtask

    // One cycle: settle, score the output and input handshakes, cross the edge.
    task automatic step();
        exp_t e, ne;
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            check("sb_nonempty", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("result", int'(obs()), int'(e.f));
                if (lat_chk) check("latency", cyc - e.acc, 3);
            end
        end
        if (accepted) begin
            ne.f   = have_dir ? next_exp : model(in_res);
            ne.acc = cyc;
            q.push_back(ne);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        check("drain_empty", q.size(), 0);
    endtask

    logic [17:0] dir_res[13];
    logic [10:0] dir_exp[13];
    logic [17:0] bp_val[6];
    logic [10:0] snap;
    bit          snap_ok;
    int          sent, base;
    int unsigned mag;

    initial begin
        dir_res = '{18'h01000, 18'h21800, 18'h00080, 18'h000C0, 18'h00040, 18'h08000,
                    18'h07F00, 18'h00FC0, 18'h00000, 18'h20000, 18'h3FFFF, 18'h00001,
                    18'h06000};
        dir_exp = '{pk(0,1,0,0,0,0),  pk(1,1,16,0,0,0), pk(0,0,1,1,0,0),  pk(0,0,2,1,0,0),
                    pk(0,0,0,1,0,1),  pk(0,3,31,0,1,0), pk(0,3,31,0,1,0), pk(0,1,0,0,0,0),
                    pk(0,0,0,1,0,0),  pk(1,0,0,1,0,0),  pk(1,3,31,0,1,0), pk(0,0,0,1,0,1),
                    pk(0,3,16,0,0,0)};

        rst = 1'b1; in_valid = 1'b0; in_res = '0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_fields", int'(obs()), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);

        // Directed corner values, back to back with latency checked.
        lat_chk  = 1;
        have_dir = 1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_res   = dir_res[i];
            next_exp = dir_exp[i];
            step();
            check("dir_accept", int'(accepted), 1);
        end
        drain();
        have_dir = 0;
        lat_chk  = 0;

        // Backpressure: six values against a stalled consumer.
        for (int i = 0; i < 6; i++) bp_val[i] = {1'($urandom()), 17'($urandom() >> 15)};
        out_ready = 1'b0;
        sent      = 0;
        snap_ok   = 0;
        base      = n_out;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_res   = bp_val[sent < 6 ? sent : 5];
            step();
            if (accepted) sent++;
            if (out_valid && !snap_ok) begin
                snap    = obs();
                snap_ok = 1;
            end else if (snap_ok) begin
                check("stall_stable", int'(obs()), int'(snap));
            end
        end
        check("stall_accepts", sent, 3);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sent < 6; k++) begin
            in_valid = 1'b1;
            in_res   = bp_val[sent];
            step();
            if (accepted) sent++;
        end
        check("bp_sent", sent, 6);
        drain();
        check("bp_emitted", n_out - base, 6);

        // Randomized traffic with random valid and ready.
        for (int k = 0; k < 400; k++) begin
            mag       = ($urandom() & 32'h1FFFF) >> $urandom_range(0, 16);
            in_res    = {1'($urandom()), 17'(mag)};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        // Reset with two results in flight: one at the output, one in stage 2.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_res    = 18'h01800;
        step();
        in_res    = 18'h23000;
        step();
        in_valid  = 1'b0;
        step();
        check("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_fields", int'(obs()), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base     = n_out;
        lat_chk  = 1;
        have_dir = 1;
        in_valid = 1'b1;
        in_res   = 18'h01000;
        next_exp = pk(0,1,0,0,0,0);
        step();
        drain();
        for (int k = 0; k < 4; k++) step();
        check("post_rst_alone", n_out - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
